// File: rtl/turn_sequencer.sv
// turn_sequencer: Connect-4 board owner and turn controller.
//
// Holds the 6x7 board and per-column fill counts. It alternates human and AI turns, starts
// the minimax engine with a one-cycle ai_start pulse and applies its answer. A rejected AI
// answer, or silence for AI_TIMEOUT cycles, is replaced by a drop into the lowest-indexed
// column that still has room. A drop that fills the last cell parks the block in a full
// state until sw goes low or reset is asserted.
//
// Optional feature macro: UNDO_EN. It adds a btn_undo input and a one-level snapshot of
// the board. The snapshot is taken on each accepted human drop.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   sw             game enable; low clears all state synchronously
//   btn_drop       human drop request pulse; sel_col[2:0] selects column 0..6 (7 invalid)
//   ai_done        minimax result pulse; ai_col[2:0] is its column
//   btn_undo       (UNDO_EN only) undo request pulse
//   grid[83:0]     cell (r,c) = grid[13-2c+14r -: 2]; 00 empty, 01 human, 10 AI
//   column_counts  pieces in column c = column_counts[3c+2 -: 3]
//   player         0 human turn, 1 AI turn
//   ai_start       one-cycle search request
//   illegal        one-cycle pulse on a rejected human drop
//   ai_fault       one-cycle pulse when the fallback move was applied
//   board_full     high once all 42 cells are occupied
//   move_count     total pieces on the board
module turn_sequencer #(
  parameter int unsigned AI_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw,
  input  logic        btn_drop,
  input  logic [2:0]  sel_col,
  input  logic        ai_done,
  input  logic [2:0]  ai_col,
`ifdef UNDO_EN
  input  logic        btn_undo,
`endif
  output logic [83:0] grid,
  output logic [20:0] column_counts,
  output logic        player,
  output logic        ai_start,
  output logic        illegal,
  output logic        ai_fault,
  output logic        board_full,
  output logic [5:0]  move_count
);

  typedef enum logic [1:0] {StHuman, StAiStart, StAiWait, StFull} state_e;

  state_e      state_q, state_d;
  logic [83:0] grid_q, grid_d;
  logic [20:0] cnt_q, cnt_d;
  logic [5:0]  mc_q, mc_d;
  logic [15:0] timer_q, timer_d;
  logic        illegal_q, illegal_d;
  logic        fault_q, fault_d;

  // Column 7 is modelled as a permanently full column so one lookup rejects both cases.
  logic [2:0]  col_cnt [8];
  logic [7:0]  col_full;
  logic [2:0]  fb_col;

  logic        wr_en;
  logic [2:0]  wr_col;
  logic [1:0]  wr_val;
  logic        undo_hit;

`ifdef UNDO_EN
  logic [83:0] snap_grid_q;
  logic [20:0] snap_cnt_q;
  logic [5:0]  snap_mc_q;
  logic        snap_valid_q;

  assign undo_hit = (state_q == StHuman) && btn_undo && snap_valid_q;
`else
  assign undo_hit = 1'b0;
`endif

  always_comb begin
    for (int c = 0; c < 7; c++) begin
      col_cnt[c]  = cnt_q[3*c +: 3];
      col_full[c] = (cnt_q[3*c +: 3] == 3'd6);
    end
    col_cnt[7]  = 3'd0;
    col_full[7] = 1'b1;
  end

  // Lowest-indexed column with room; only consulted while the board is not full.
  always_comb begin
    fb_col = 3'd0;
    for (int c = 6; c >= 0; c--) begin
      if (!col_full[c]) fb_col = 3'(c);
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    cnt_d     = cnt_q;
    mc_d      = mc_q;
    timer_d   = timer_q;
    illegal_d = 1'b0;
    fault_d   = 1'b0;
    wr_en     = 1'b0;
    wr_col    = 3'd0;
    wr_val    = 2'b00;

    unique case (state_q)
      StHuman: begin
        if (btn_drop && !undo_hit) begin
          if (!col_full[sel_col]) begin
            wr_en  = 1'b1;
            wr_col = sel_col;
            wr_val = 2'b01;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StAiStart: begin
        timer_d = 16'd0;
        state_d = StAiWait;
      end
      StAiWait: begin
        timer_d = timer_q + 16'd1;
        // ai_done takes priority over a timeout landing in the same cycle.
        if (ai_done) begin
          wr_en  = 1'b1;
          wr_val = 2'b10;
          if (!col_full[ai_col]) begin
            wr_col = ai_col;
          end else begin
            wr_col  = fb_col;
            fault_d = 1'b1;
          end
        end else if (timer_q == 16'(AI_TIMEOUT)) begin
          wr_en   = 1'b1;
          wr_val  = 2'b10;
          wr_col  = fb_col;
          fault_d = 1'b1;
        end
      end
      StFull: begin
      end
      default: state_d = StHuman;
    endcase

    if (wr_en) begin
      for (int c = 0; c < 7; c++) begin
        if (wr_col == 3'(c)) begin
          for (int r = 0; r < 6; r++) begin
            if (col_cnt[c] == 3'(r)) grid_d[13 - 2*c + 14*r -: 2] = wr_val;
          end
          cnt_d[3*c +: 3] = col_cnt[c] + 3'd1;
        end
      end
      mc_d = mc_q + 6'd1;
      if (mc_q == 6'd41)            state_d = StFull;
      else if (state_q == StHuman)  state_d = StAiStart;
      else                          state_d = StHuman;
    end

`ifdef UNDO_EN
    if (undo_hit) begin
      grid_d = snap_grid_q;
      cnt_d  = snap_cnt_q;
      mc_d   = snap_mc_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHuman;
      grid_q    <= '0;
      cnt_q     <= '0;
      mc_q      <= '0;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (!sw) begin
      state_q   <= StHuman;
      grid_q    <= '0;
      cnt_q     <= '0;
      mc_q      <= '0;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      cnt_q     <= cnt_d;
      mc_q      <= mc_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

`ifdef UNDO_EN
  // Snapshot holds the board as it was just before the latest accepted human drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_grid_q  <= '0;
      snap_cnt_q   <= '0;
      snap_mc_q    <= '0;
      snap_valid_q <= 1'b0;
    end else if (!sw) begin
      snap_grid_q  <= '0;
      snap_cnt_q   <= '0;
      snap_mc_q    <= '0;
      snap_valid_q <= 1'b0;
    end else if (undo_hit) begin
      snap_valid_q <= 1'b0;
    end else if (wr_en && state_q == StHuman) begin
      snap_grid_q  <= grid_q;
      snap_cnt_q   <= cnt_q;
      snap_mc_q    <= mc_q;
      snap_valid_q <= 1'b1;
    end
  end
`endif

  assign grid          = grid_q;
  assign column_counts = cnt_q;
  assign move_count    = mc_q;
  assign illegal       = illegal_q;
  assign ai_fault      = fault_q;
  assign player        = (state_q == StAiStart) || (state_q == StAiWait);
  assign ai_start      = (state_q == StAiStart);
  assign board_full    = (state_q == StFull);

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: stimulus tasks push the expected board/flag snapshot,
// a forked monitor pops and compares whenever the DUT shows a pulse or a move_count change.
module tb_turn_sequencer;

  logic        clk;
  logic        rst_n;
  logic        sw;
  logic        btn_drop;
  logic [2:0]  sel_col;
  logic        ai_done;
  logic [2:0]  ai_col;
`ifdef UNDO_EN
  logic        btn_undo;
`endif
  logic [83:0] grid;
  logic [20:0] column_counts;
  logic        player;
  logic        ai_start;
  logic        illegal;
  logic        ai_fault;
  logic        board_full;
  logic [5:0]  move_count;

  turn_sequencer #(.AI_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_drop     (btn_drop),
    .sel_col      (sel_col),
    .ai_done      (ai_done),
    .ai_col       (ai_col),
`ifdef UNDO_EN
    .btn_undo     (btn_undo),
`endif
    .grid         (grid),
    .column_counts(column_counts),
    .player       (player),
    .ai_start     (ai_start),
    .illegal      (illegal),
    .ai_fault     (ai_fault),
    .board_full   (board_full),
    .move_count   (move_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // flags = {player, ai_start, illegal, ai_fault, board_full}
  typedef struct {
    logic [83:0] grid;
    logic [20:0] cnt;
    logic [5:0]  mc;
    logic [4:0]  flags;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests;
  int         n_fail;

  logic [1:0] board [6][7];
  int         cnt_m [7];
  int         mc_m;

  task automatic chk(input string name, input logic [83:0] got, input logic [83:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) board[r][c] = 2'b00;
    for (int c = 0; c < 7; c++) cnt_m[c] = 0;
    mc_m = 0;
  endfunction

  function automatic logic [83:0] model_grid();
    logic [83:0] g;
    g = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) g[13 - 2*c + 14*r -: 2] = board[r][c];
    return g;
  endfunction

  function automatic logic [20:0] model_cnt();
    logic [20:0] v;
    v = '0;
    for (int c = 0; c < 7; c++) v[3*c +: 3] = 3'(cnt_m[c]);
    return v;
  endfunction

  function automatic void place(input int col, input logic [1:0] v);
    board[cnt_m[col]][col] = v;
    cnt_m[col]++;
    mc_m++;
  endfunction

  function automatic int first_free();
    for (int c = 0; c < 7; c++) if (cnt_m[c] < 6) return c;
    return 0;
  endfunction

  task automatic push(input logic [4:0] flags);
    exp_t e;
    e.grid  = model_grid();
    e.cnt   = model_cnt();
    e.mc    = 6'(mc_m);
    e.flags = flags;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    logic [5:0] prev_mc;
    exp_t e;
    prev_mc = '0;
    forever begin
      @(negedge clk);
      if (ai_start || illegal || ai_fault || move_count != prev_mc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {move_count, player, ai_start, illegal, ai_fault, board_full},
              {prev_mc, 5'b0});
        end else begin
          e = exp_q.pop_front();
          chk("ev_grid", grid, e.grid);
          chk("ev_counts", 84'(column_counts), 84'(e.cnt));
          chk("ev_move_count", 84'(move_count), 84'(e.mc));
          chk("ev_flags", 84'({player, ai_start, illegal, ai_fault, board_full}), 84'(e.flags));
        end
      end
      prev_mc = move_count;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 84'(exp_q.size()), 84'd0);
      exp_q.delete();
    end
  endtask

  task automatic human_drop(input int col);
    @(negedge clk);
    btn_drop = 1'b1;
    sel_col  = 3'(col);
    if (col > 6 || cnt_m[col > 6 ? 0 : col] == 6) begin
      push(5'b00100);
    end else begin
      place(col, 2'b01);
      push(mc_m == 42 ? 5'b00001 : 5'b11000);
    end
    @(negedge clk);
    btn_drop = 1'b0;
    sel_col  = 3'd0;
  endtask

  task automatic ai_move(input int col);
    @(negedge clk);
    ai_done = 1'b1;
    ai_col  = 3'(col);
    if (col <= 6 && cnt_m[col > 6 ? 0 : col] < 6) begin
      place(col, 2'b10);
      push(mc_m == 42 ? 5'b00001 : 5'b00000);
    end else begin
      place(first_free(), 2'b10);
      push(mc_m == 42 ? 5'b00011 : 5'b00010);
    end
    @(negedge clk);
    ai_done = 1'b0;
    ai_col  = 3'd0;
  endtask

  task automatic game_clear();
    @(negedge clk);
    sw = 1'b0;
    if (mc_m != 0) begin
      model_clear();
      push(5'b00000);
    end
    @(negedge clk);
    sw = 1'b1;
    chk("clear_move_count", 84'(move_count), 84'd0);
    chk("clear_grid", grid, 84'd0);
  endtask

  initial begin
    logic [5:0] mc_before;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sw       = 1'b1;
    btn_drop = 1'b0;
    sel_col  = 3'd0;
    ai_done  = 1'b0;
    ai_col   = 3'd0;
`ifdef UNDO_EN
    btn_undo = 1'b0;
`endif
    model_clear();
    repeat (3) @(negedge clk);

    chk("reset_grid", grid, 84'd0);
    chk("reset_counts", 84'(column_counts), 84'd0);
    chk("reset_move_count", 84'(move_count), 84'd0);
    chk("reset_flags", 84'({player, ai_start, illegal, ai_fault, board_full}), 84'd0);
    rst_n = 1'b1;

    fork
      monitor();
    join_none

    // Human drop into column 3, then AI into column 3.
    human_drop(3);
    chk("t1_cell", 84'(grid[7:6]), 84'(2'b01));
    chk("t1_count", 84'(column_counts[11:9]), 84'd1);
    @(negedge clk);
    chk("t1_start_one_cycle", 84'({ai_start, player}), 84'(2'b01));
    ai_move(3);
    chk("t2_cell", 84'(grid[21:20]), 84'(2'b10));
    chk("t2_count", 84'(column_counts[11:9]), 84'd2);
    chk("t2_move_count", 84'(move_count), 84'd2);

    // Stray ai_done while it is the human's turn does nothing.
    @(negedge clk);
    ai_done = 1'b1;
    ai_col  = 3'd0;
    @(negedge clk);
    ai_done = 1'b0;
    chk("ai_done_in_human", 84'(move_count), 84'd2);

    // Fill column 0, then try illegal drops.
    for (int i = 0; i < 3; i++) begin
      human_drop(0);
      ai_move(0);
    end
    chk("col0_full", 84'(column_counts[2:0]), 84'd6);
    human_drop(0);
    human_drop(7);
    chk("illegal_keeps_turn", 84'(player), 84'd0);

    // Timeout with column 0 full: fallback lands in column 1 row 0.
    human_drop(5);
    mc_before = 6'(mc_m);
    place(first_free(), 2'b10);
    push(5'b00010);
    repeat (9) @(negedge clk);
    chk("no_early_timeout", 84'(move_count), 84'(mc_before));
    drain(20);
    chk("t4_fallback_cell", 84'(grid[11:10]), 84'(2'b10));

    // Illegal AI answers: column 7, then the full column 0.
    human_drop(6);
    @(negedge clk);
    btn_drop = 1'b1;
    sel_col  = 3'd2;
    @(negedge clk);
    btn_drop = 1'b0;
    ai_move(7);
    human_drop(6);
    ai_move(0);
    chk("t4_col1_count", 84'(column_counts[5:3]), 84'd3);

    // Fill the whole board.
    game_clear();
    for (int i = 0; i < 42; i += 2) begin
      human_drop(i / 6);
      ai_move(i / 6);
    end
    drain(10);
    chk("t5_full", 84'({board_full, player}), 84'(2'b10));
    chk("t5_move_count", 84'(move_count), 84'd42);
    @(negedge clk);
    btn_drop = 1'b1;
    sel_col  = 3'd0;
    @(negedge clk);
    btn_drop = 1'b0;
    chk("t5_full_ignores_drop", 84'(move_count), 84'd42);
    game_clear();
    chk("t5_cleared_flags", 84'({player, board_full}), 84'd0);

    // Clear during a search; a late ai_done must be ignored.
    human_drop(3);
    game_clear();
    @(negedge clk);
    ai_done = 1'b1;
    ai_col  = 3'd3;
    @(negedge clk);
    ai_done = 1'b0;
    chk("late_ai_done", 84'({move_count, player}), 84'd0);

`ifdef UNDO_EN
    human_drop(2);
    ai_move(4);
    @(negedge clk);
    btn_undo = 1'b1;
    model_clear();
    push(5'b00000);
    @(negedge clk);
    btn_undo = 1'b0;
    chk("undo_grid", grid, 84'd0);
    chk("undo_counts", 84'(column_counts), 84'd0);
    @(negedge clk);
    btn_undo = 1'b1;
    @(negedge clk);
    btn_undo = 1'b0;
    chk("undo_no_snapshot", 84'({move_count, player}), 84'd0);
    human_drop(1);
    ai_move(1);
    @(negedge clk);
    btn_undo = 1'b1;
    btn_drop = 1'b1;
    sel_col  = 3'd5;
    model_clear();
    push(5'b00000);
    @(negedge clk);
    btn_undo = 1'b0;
    btn_drop = 1'b0;
    chk("undo_beats_drop", 84'({move_count, player}), 84'd0);
`endif

    drain(10);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
